// File: rtl/icache_refill_if.sv
// Signal bundle between the refill engine, the fetch-side cache and the instruction memory port.
// The master modport is the refill engine; the slave modport is its environment.
interface icache_refill_if #(
   parameter int BLOCK_WIDTH = 512,
   parameter int WORD_SIZE   = 32,
   parameter int ADDR_WIDTH  = 64
);
   logic                   i_miss;
   logic [ADDR_WIDTH-1:0]  i_miss_addr;
   logic                   o_busy;
   logic [ADDR_WIDTH-1:0]  o_fill_addr;
   logic [BLOCK_WIDTH-1:0] o_block;
   logic                   o_block_we;
   logic                   o_err;
   logic                   o_mem_req_valid;
   logic                   i_mem_req_ready;
   logic [ADDR_WIDTH-1:0]  o_mem_req_addr;
   logic                   i_mem_rdata_valid;
   logic [WORD_SIZE-1:0]   i_mem_rdata;
   logic                   i_mem_rdata_last;
   logic                   i_mem_rerror;

   modport master (
      input  i_miss, i_miss_addr, i_mem_req_ready,
      input  i_mem_rdata_valid, i_mem_rdata, i_mem_rdata_last, i_mem_rerror,
      output o_busy, o_fill_addr, o_block, o_block_we, o_err,
      output o_mem_req_valid, o_mem_req_addr
   );

   modport slave (
      output i_miss, i_miss_addr, i_mem_req_ready,
      output i_mem_rdata_valid, i_mem_rdata, i_mem_rdata_last, i_mem_rerror,
      input  o_busy, o_fill_addr, o_block, o_block_we, o_err,
      input  o_mem_req_valid, o_mem_req_addr
   );
endinterface

// File: rtl/icache_refill.sv
// Instruction-cache line-fill engine: one burst read per miss, beats assembled into a
// full line, then a single-cycle block write (or a single-cycle error pulse) to the cache.
module icache_refill #(
   parameter int BLOCK_WIDTH = 512,
   parameter int WORD_SIZE   = 32,
   parameter int ADDR_WIDTH  = 64
) (
   input  logic            clk,
   input  logic            arst,
   icache_refill_if.master bus
);
   localparam int BEATS      = BLOCK_WIDTH / WORD_SIZE;
   localparam int LINE_OFF_W = $clog2(BLOCK_WIDTH / 8);
   localparam int CNT_W      = $clog2(BEATS);

   localparam logic [CNT_W-1:0]      LAST_CNT  = CNT_W'(BEATS - 1);
   localparam logic [CNT_W-1:0]      CNT_ONE   = CNT_W'(1);
   localparam logic [ADDR_WIDTH-1:0] LINE_MASK = {{(ADDR_WIDTH-LINE_OFF_W){1'b0}}, {LINE_OFF_W{1'b1}}};

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_REQ   = 2'd1,
      S_FILL  = 2'd2,
      S_WRITE = 2'd3
   } state_e;

   state_e                 state_q, state_d;
   logic [CNT_W-1:0]       cnt_q, cnt_d;
   logic [ADDR_WIDTH-1:0]  addr_q, addr_d;
   logic [BLOCK_WIDTH-1:0] block_q, block_d;
   logic                   err_q, err_d;
   logic                   beat_err_s;

   // Next-state, beat assembly and error detection.
   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q;
      addr_d     = addr_q;
      block_d    = block_q;
      err_d      = 1'b0;
      beat_err_s = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (bus.i_miss) begin
               addr_d  = bus.i_miss_addr & ~LINE_MASK;
               state_d = S_REQ;
            end else begin
               state_d = S_IDLE;
            end
         end
         S_REQ: begin
            if (bus.i_mem_req_ready) begin
               cnt_d   = {CNT_W{1'b0}};
               state_d = S_FILL;
            end else begin
               state_d = S_REQ;
            end
         end
         S_FILL: begin
            if (bus.i_mem_rdata_valid) begin
               for (int b = 0; b < BEATS; b++) begin
                  if (cnt_q == CNT_W'(b)) begin
                     block_d[b*WORD_SIZE +: WORD_SIZE] = bus.i_mem_rdata;
                  end else begin
                     block_d[b*WORD_SIZE +: WORD_SIZE] = block_q[b*WORD_SIZE +: WORD_SIZE];
                  end
               end
               // A last marker must coincide exactly with the final beat position.
               beat_err_s = bus.i_mem_rerror | (bus.i_mem_rdata_last != (cnt_q == LAST_CNT));
               cnt_d      = cnt_q + CNT_ONE;
               if (beat_err_s) begin
                  err_d   = 1'b1;
                  state_d = S_IDLE;
               end else if (cnt_q == LAST_CNT) begin
                  state_d = S_WRITE;
               end else begin
                  state_d = S_FILL;
               end
            end else begin
               state_d = S_FILL;
            end
         end
         S_WRITE: begin
            state_d = S_IDLE;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   // State and datapath registers with synchronous reset.
   always_ff @(posedge clk) begin
      if (arst) begin
         state_q <= S_IDLE;
         cnt_q   <= {CNT_W{1'b0}};
         addr_q  <= {ADDR_WIDTH{1'b0}};
         block_q <= {BLOCK_WIDTH{1'b0}};
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         addr_q  <= addr_d;
         block_q <= block_d;
         err_q   <= err_d;
      end
   end

   assign bus.o_busy          = (state_q != S_IDLE);
   assign bus.o_mem_req_valid = (state_q == S_REQ);
   assign bus.o_block_we      = (state_q == S_WRITE);
   assign bus.o_err           = err_q;
   assign bus.o_fill_addr     = addr_q;
   assign bus.o_mem_req_addr  = addr_q;
   assign bus.o_block         = block_q;
endmodule

// File: tb/tb_icache_refill.sv
// Directed self-checking bench for icache_refill: expected refill outcomes are queued when a
// miss is driven and compared when the engine writes a line or pulses its error output.
module tb_icache_refill;
   logic clk = 1'b0;
   logic arst;

   always #5 clk = ~clk;

   icache_refill_if bus ();

   icache_refill dut (
      .clk  (clk),
      .arst (arst),
      .bus  (bus)
   );

   typedef struct {
      logic         is_err;
      logic [63:0]  addr;
      logic [511:0] block;
   } exp_t;

   exp_t sb[$];
   int   n_pass  = 0;
   int   n_total = 0;
   int   edge_cnt = 0;
   int   we_cnt   = 0;
   int   err_cnt  = 0;
   int   req_cnt  = 0;

   // Edge and event counters used for latency and pulse-count checks.
   always @(posedge clk) begin
      edge_cnt <= edge_cnt + 1;
      if (bus.o_block_we === 1'b1) we_cnt <= we_cnt + 1;
      if (bus.o_err === 1'b1) err_cnt <= err_cnt + 1;
      if (bus.o_mem_req_valid === 1'b1 && bus.i_mem_req_ready === 1'b1) req_cnt <= req_cnt + 1;
   end

   initial begin
      #400000;
      $display("FAIL global_timeout observed=running expected=finished");
      $fatal(1, "bench timeout");
   end

   task automatic chk(input string tag, input logic [511:0] obs, input logic [511:0] exp);
      n_total++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
   endtask

   task automatic chk_bit(input string tag, input logic obs, input logic exp);
      n_total++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
   endtask

   task automatic chk_int(input string tag, input int obs, input int exp);
      n_total++;
      assert (obs == exp) n_pass++;
      else $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
   endtask

   function automatic logic [511:0] mk_block(input logic [31:0] base);
      logic [511:0] b;
      b = 512'h0;
      for (int k = 0; k < 16; k++) b[k*32 +: 32] = base + 32'(k);
      return b;
   endfunction

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) @(negedge clk);
   endtask

   task automatic do_miss(input logic [63:0] a);
      bus.i_miss      = 1'b1;
      bus.i_miss_addr = a;
      @(negedge clk);
      bus.i_miss      = 1'b0;
   endtask

   task automatic do_req(input logic [63:0] exp_addr, input int delay);
      for (int d = 0; d < delay; d++) begin
         bus.i_mem_req_ready = 1'b0;
         chk_bit("req_valid_hold", bus.o_mem_req_valid, 1'b1);
         chk("req_addr_hold", 512'(bus.o_mem_req_addr), 512'(exp_addr));
         @(negedge clk);
      end
      chk_bit("req_valid", bus.o_mem_req_valid, 1'b1);
      chk("req_addr", 512'(bus.o_mem_req_addr), 512'(exp_addr));
      bus.i_mem_req_ready = 1'b1;
      @(negedge clk);
      bus.i_mem_req_ready = 1'b0;
      chk_bit("req_valid_drop", bus.o_mem_req_valid, 1'b0);
   endtask

   task automatic send_beats(input logic [31:0] base, input int from, input int to,
                             input bit gap, input int err_beat, input int last_beat);
      for (int k = from; k <= to; k++) begin
         if (gap && k != from) begin
            bus.i_mem_rdata_valid = 1'b0;
            @(negedge clk);
         end
         bus.i_mem_rdata_valid = 1'b1;
         bus.i_mem_rdata       = base + 32'(k);
         bus.i_mem_rdata_last  = (k == last_beat);
         bus.i_mem_rerror      = (k == err_beat);
         @(negedge clk);
      end
      bus.i_mem_rdata_valid = 1'b0;
      bus.i_mem_rdata_last  = 1'b0;
      bus.i_mem_rerror      = 1'b0;
   endtask

   task automatic wait_outcome(output int polls);
      exp_t e;
      polls = 0;
      while (bus.o_block_we !== 1'b1 && bus.o_err !== 1'b1 && polls < 40) begin
         @(negedge clk);
         polls++;
      end
      chk_bit("outcome_seen", bus.o_block_we | bus.o_err, 1'b1);
      if (polls >= 40) return;
      chk_bit("outcome_expected", sb.size() != 0, 1'b1);
      if (sb.size() == 0) return;
      e = sb.pop_front();
      chk_bit("outcome_err", bus.o_err, e.is_err);
      chk_bit("outcome_we", bus.o_block_we, ~e.is_err);
      if (!e.is_err) begin
         chk("fill_addr", 512'(bus.o_fill_addr), 512'(e.addr));
         chk("block", bus.o_block, e.block);
      end else begin
         chk_bit("busy_after_err", bus.o_busy, 1'b0);
      end
   endtask

   initial begin
      int polls;
      int e_miss;
      int we0, err0, req0;

      arst                  = 1'b1;
      bus.i_miss            = 1'b0;
      bus.i_miss_addr       = 64'h0;
      bus.i_mem_req_ready   = 1'b0;
      bus.i_mem_rdata_valid = 1'b0;
      bus.i_mem_rdata       = 32'h0;
      bus.i_mem_rdata_last  = 1'b0;
      bus.i_mem_rerror      = 1'b0;
      idle(2);
      chk_bit("rst_busy", bus.o_busy, 1'b0);
      chk_bit("rst_we", bus.o_block_we, 1'b0);
      chk_bit("rst_err", bus.o_err, 1'b0);
      chk_bit("rst_req_valid", bus.o_mem_req_valid, 1'b0);
      chk("rst_fill_addr", 512'(bus.o_fill_addr), 512'h0);
      chk("rst_block", bus.o_block, 512'h0);
      arst = 1'b0;
      idle(1);

      // Basic fill with latency check.
      we0 = we_cnt;
      e_miss = edge_cnt;
      sb.push_back('{1'b0, 64'h0000_0000_8000_1200, mk_block(32'hA000_0000)});
      do_miss(64'h0000_0000_8000_1234);
      chk_bit("busy_in_req", bus.o_busy, 1'b1);
      do_req(64'h0000_0000_8000_1200, 0);
      send_beats(32'hA000_0000, 0, 15, 1'b0, -1, 15);
      wait_outcome(polls);
      chk_int("we_latency", edge_cnt - e_miss, 18);
      chk("block_word0", 512'(bus.o_block[31:0]), 512'(32'hA000_0000));
      chk("block_word15", 512'(bus.o_block[511:480]), 512'(32'hA000_000F));
      idle(1);
      chk_bit("busy_low_after_write", bus.o_busy, 1'b0);
      chk_bit("we_one_cycle", bus.o_block_we, 1'b0);
      idle(2);
      chk_int("basic_we_count", we_cnt - we0, 1);

      // Backpressure on the request and gaps between beats.
      we0 = we_cnt;
      sb.push_back('{1'b0, 64'h0000_0000_8000_1200, mk_block(32'hA000_0000)});
      do_miss(64'h0000_0000_8000_123C);
      do_req(64'h0000_0000_8000_1200, 5);
      send_beats(32'hA000_0000, 0, 15, 1'b1, -1, 15);
      wait_outcome(polls);
      idle(3);
      chk_int("gap_we_count", we_cnt - we0, 1);

      // Early last on beat 9, followed by a normal refill.
      we0 = we_cnt;
      err0 = err_cnt;
      sb.push_back('{1'b1, 64'h0, 512'h0});
      do_miss(64'h0000_0000_0000_2048);
      do_req(64'h0000_0000_0000_2040, 0);
      send_beats(32'h5500_0000, 0, 9, 1'b0, -1, 9);
      wait_outcome(polls);
      chk_int("early_last_err_latency", polls, 0);
      send_beats(32'h5500_0000, 10, 15, 1'b0, -1, 15);
      idle(2);
      chk_int("early_last_we_count", we_cnt - we0, 0);
      chk_int("early_last_err_count", err_cnt - err0, 1);
      sb.push_back('{1'b0, 64'h0000_0000_0000_2040, mk_block(32'h1234_0000)});
      do_miss(64'h0000_0000_0000_2050);
      do_req(64'h0000_0000_0000_2040, 0);
      send_beats(32'h1234_0000, 0, 15, 1'b0, -1, 15);
      wait_outcome(polls);
      idle(2);

      // Error response on beat 3; remaining beats arrive while idle.
      we0 = we_cnt;
      err0 = err_cnt;
      sb.push_back('{1'b1, 64'h0, 512'h0});
      do_miss(64'h0000_0001_0000_0FC0);
      do_req(64'h0000_0001_0000_0FC0, 0);
      send_beats(32'h7700_0000, 0, 3, 1'b0, 3, 15);
      wait_outcome(polls);
      chk_int("rerror_err_latency", polls, 0);
      send_beats(32'h7700_0000, 4, 15, 1'b0, -1, 15);
      idle(2);
      chk_int("rerror_we_count", we_cnt - we0, 0);
      chk_int("rerror_err_count", err_cnt - err0, 1);
      chk_bit("rerror_busy", bus.o_busy, 1'b0);

      // Miss while busy is dropped; re-asserted miss starts a second request.
      req0 = req_cnt;
      sb.push_back('{1'b0, 64'h0000_0000_0000_1000, mk_block(32'hC000_0000)});
      do_miss(64'h0000_0000_0000_1010);
      do_req(64'h0000_0000_0000_1000, 0);
      bus.i_miss      = 1'b1;
      bus.i_miss_addr = 64'h0000_0000_0000_4000;
      send_beats(32'hC000_0000, 0, 15, 1'b0, -1, 15);
      bus.i_miss      = 1'b0;
      wait_outcome(polls);
      idle(2);
      chk_int("busy_miss_req_count", req_cnt - req0, 1);
      chk_bit("busy_miss_idle", bus.o_busy, 1'b0);
      sb.push_back('{1'b0, 64'h0000_0000_0000_4000, mk_block(32'hD000_0000)});
      do_miss(64'h0000_0000_0000_4000);
      do_req(64'h0000_0000_0000_4000, 0);
      send_beats(32'hD000_0000, 0, 15, 1'b0, -1, 15);
      wait_outcome(polls);
      idle(2);
      chk_int("second_req_count", req_cnt - req0, 2);

      // Reset in mid-fill after beat 7.
      we0 = we_cnt;
      err0 = err_cnt;
      do_miss(64'h0000_0000_9000_0000);
      do_req(64'h0000_0000_9000_0000, 0);
      send_beats(32'hE000_0000, 0, 7, 1'b0, -1, 15);
      arst = 1'b1;
      @(negedge clk);
      chk_bit("mid_rst_busy", bus.o_busy, 1'b0);
      chk_bit("mid_rst_req_valid", bus.o_mem_req_valid, 1'b0);
      chk_bit("mid_rst_we", bus.o_block_we, 1'b0);
      chk_bit("mid_rst_err", bus.o_err, 1'b0);
      chk("mid_rst_fill_addr", 512'(bus.o_fill_addr), 512'h0);
      chk("mid_rst_req_addr", 512'(bus.o_mem_req_addr), 512'h0);
      chk("mid_rst_block", bus.o_block, 512'h0);
      arst = 1'b0;
      send_beats(32'hE000_0000, 8, 15, 1'b0, -1, 15);
      idle(3);
      chk_int("mid_rst_we_count", we_cnt - we0, 0);
      chk_int("mid_rst_err_count", err_cnt - err0, 0);
      chk_int("sb_drained", sb.size(), 0);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end
endmodule

// File: doc/icache_refill.md
Name: icache_refill

Overview:
- Line-fill engine on the memory side of the direct-mapped instruction cache.
- On a fetch miss it issues one burst read for the 64-byte line containing the miss address.
- It assembles the returned 32-bit beats into a 512-bit block, then drives the cache's block-write interface for exactly one cycle.
- It sits between the fetch-stage cache and the instruction memory port.

Parameters:
- BLOCK_WIDTH, 512: cache line width in bits.
- WORD_SIZE, 32: memory beat width in bits.
- ADDR_WIDTH, 64: address width in bits.
- Derived: BEATS = BLOCK_WIDTH/WORD_SIZE (16); LINE_OFF_W = $clog2(BLOCK_WIDTH/8) (6).

Ports:
- clk, input, 1: single clock; all logic is on the rising edge.
- arst, input, 1: reset, synchronous, active-high.
- i_miss, input, 1: cache miss; sampled only in IDLE.
- i_miss_addr, input, ADDR_WIDTH: fetch address of the miss.
- o_busy, output, 1: refill in progress; the fetch stage stalls while it is high.
- o_fill_addr, output, ADDR_WIDTH: latched line-aligned address; the cache indexes/tags with it during the write.
- o_block, output, BLOCK_WIDTH: assembled line.
- o_block_we, output, 1: one-cycle write strobe to the cache.
- o_err, output, 1: one-cycle pulse on a failed refill.
- o_mem_req_valid, output, 1: burst read request valid.
- i_mem_req_ready, input, 1: memory accepts the request.
- o_mem_req_addr, output, ADDR_WIDTH: burst start address (line-aligned).
- i_mem_rdata_valid, input, 1: read beat valid.
- i_mem_rdata, input, WORD_SIZE: read beat data.
- i_mem_rdata_last, input, 1: final beat marker.
- i_mem_rerror, input, 1: beat carries an error response.

Behaviour:
- Reset (arst=1 at a rising edge, in any state):
  - State goes to IDLE and the beat counter is cleared.
  - o_busy, o_block_we, o_err and o_mem_req_valid are 0; o_fill_addr, o_mem_req_addr and o_block are 0.
  - Reset in mid-burst abandons the burst with no write. Beats arriving after reset are ignored.
- States: IDLE, REQ, FILL, WRITE.
  - o_busy = (state != IDLE); it is combinational from the state register.
- IDLE:
  - If i_miss=1, latch line_addr = i_miss_addr with bits [LINE_OFF_W-1:0] cleared into o_fill_addr/o_mem_req_addr, then go to REQ.
  - i_mem_rdata_valid is ignored in IDLE.
- REQ:
  - o_mem_req_valid=1; the address is held stable until the handshake.
  - On valid&ready, clear the beat counter and go to FILL; o_mem_req_valid drops the next cycle.
  - Beats arriving in REQ are ignored.
- FILL:
  - Each cycle with i_mem_rdata_valid=1 writes i_mem_rdata into o_block[cnt*WORD_SIZE +: WORD_SIZE], then increments cnt. Beat 0 is the lowest word (cache word offset 0).
  - Gaps (valid=0) are allowed; there is no timeout.
  - Error: i_mem_rerror=1 on any beat, or a last/count mismatch (last=1 with cnt<BEATS-1, or last=0 with cnt==BEATS-1). On error, o_err pulses the next cycle, there is no write, the state returns to IDLE and o_block keeps partial data.
  - A valid final beat (cnt==BEATS-1, last=1, no error) goes to WRITE.
- WRITE:
  - o_block_we=1 for exactly one cycle with o_block and o_fill_addr stable, then IDLE.
- Busy and concurrent inputs:
  - i_miss while busy is ignored and not queued; the cache re-asserts the miss after refill if it still misses.
  - A simultaneous i_miss in the cycle WRITE returns to IDLE is not accepted until the next cycle (one idle cycle between refills).
- Latency with ready=1 and back-to-back beats:
  - Miss seen at edge 0, REQ handshake at edge 1, beats at edges 2..17, o_block_we high in cycle 18, o_busy low from cycle 19.
- The counter is $clog2(BEATS) bits wide; its wrap from BEATS-1 is never used, because the state exits FILL on the final beat.

Test Plan:
- Basic fill:
  - Stimulus: miss at 0x0000_0000_8000_1234; ready=1; 16 back-to-back beats with data 0xA000_0000+k.
  - Required response: o_mem_req_addr=0x8000_1200; o_block_we in cycle 18; o_block[31:0]=0xA000_0000, o_block[511:480]=0xA000_000F; o_fill_addr=0x8000_1200.
- Backpressure and gaps:
  - Stimulus: ready held low for 5 cycles; valid toggled 1,0,1,0 across all beats.
  - Required response: req_valid/address stable until ready; block identical to the gap-free case; exactly one o_block_we pulse.
- Early last:
  - Stimulus: last=1 on beat 9.
  - Required response: o_err pulse, no o_block_we, o_busy low the cycle after, next miss accepted normally.
- rerror on beat 3:
  - Required response: o_err pulse, no write; subsequent beats ignored in IDLE.
- Miss while busy:
  - Stimulus: i_miss with 0x4000 asserted during FILL.
  - Required response: ignored; only one request issued; a second request issued only after o_busy falls and i_miss is re-asserted.
- Reset in mid-FILL after beat 7:
  - Required response: all outputs 0 next cycle; remaining beats produce no write and no o_err.
